// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative multiply/divide engine for the EX stage.
//
// Computes MULT, MULTU, DIV and DIVU one bit per clock: shift-add for
// multiplication, restoring shift-subtract for division. Signed operations
// run on operand magnitudes and the sign is fixed up in a final cycle.
//
// Handshake (valid/ready style): the unit is ready when busy==0. A request
// is accepted at a rising edge where start==1, flush==0 and the unit is idle;
// operands are captured at that edge. busy is high from the next cycle until
// the result is written. done is high for exactly one cycle when
// doutHi/doutLo/divZero hold a fresh result; it never overlaps busy, so a new
// start may be presented in the done cycle. flush aborts any operation in
// flight without producing done and without touching the result registers.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   start        request a new operation (sampled only when idle)
//   mdOp         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   din1, din2   rs / rt operands
//   flush        abort the in-flight operation
//   busy         operation in progress
//   done         one-cycle result-valid pulse
//   doutHi       product high half / remainder
//   doutLo       product low half / quotient
//   divZero      last result came from a division by zero
//   state_dbg_o  current FSM state (IDLE=0, RUN=1, FIX=2)

module md_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mdOp,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] doutHi,
    output logic [WIDTH-1:0] doutLo,
    output logic             divZero,
    output logic [1:0]       state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;      // product / quotient must be negated
    logic             rneg_q, rneg_d;    // remainder must be negated
    logic             dz_q, dz_d;        // divisor was zero
    logic [WIDTH-1:0] din1_q, din1_d;    // raw dividend for the div-by-zero result
    logic [WIDTH-1:0] b_q, b_d;          // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_q, hi_d;        // partial product high half / remainder
    logic [WIDTH-1:0] lo_q, lo_d;        // multiplier bits / dividend-quotient bits
    logic             done_q, done_d;
    logic [WIDTH-1:0] dout_hi_q, dout_hi_d;
    logic [WIDTH-1:0] dout_lo_q, dout_lo_d;
    logic             div_zero_q, div_zero_d;

    // Datapath helpers
    logic             signed_op;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        signed_op = ~mdOp[0];
        mag1      = (signed_op && din1[WIDTH-1]) ? -din1 : din1;
        mag2      = (signed_op && din2[WIDTH-1]) ? -din2 : din2;

        // Multiply step: add multiplicand when the current multiplier bit is set.
        add_sum   = {1'b0, hi_q} + {1'b0, b_q};

        // Divide step: bring the next dividend bit into the partial remainder
        // and try to subtract. The partial remainder needs one extra bit
        // because 2*rem+1 can exceed WIDTH bits.
        shifted   = {hi_q, lo_q[WIDTH-1]};
        trial     = shifted - {1'b0, b_q};

        prod      = {hi_q, lo_q};
        prod_fix  = neg_q ? -prod : prod;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        dz_d       = dz_q;
        din1_d     = din1_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dout_hi_d  = dout_hi_q;
        dout_lo_d  = dout_lo_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d  = S_RUN;
                    cnt_d    = CNT_LOAD;
                    is_div_d = mdOp[1];
                    neg_d    = signed_op && (din1[WIDTH-1] ^ din2[WIDTH-1]);
                    rneg_d   = signed_op && din1[WIDTH-1];
                    dz_d     = (din2 == '0);
                    din1_d   = din1;
                    hi_d     = '0;
                    if (mdOp[1]) begin
                        b_d  = mag2;
                        lo_d = mag1;
                    end else begin
                        b_d  = mag1;
                        lo_d = mag2;
                    end
                end
            end

            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIX;
                    end
                    if (is_div_q) begin
                        if (!trial[WIDTH]) begin
                            hi_d = trial[WIDTH-1:0];
                            lo_d = {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_d = shifted[WIDTH-1:0];
                            lo_d = {lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (lo_q[0]) begin
                            {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
                        end else begin
                            {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
                        end
                    end
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        div_zero_d = dz_q;
                        if (dz_q) begin
                            dout_lo_d = '1;
                            dout_hi_d = din1_q;
                        end else begin
                            dout_lo_d = neg_q  ? -lo_q : lo_q;
                            dout_hi_d = rneg_q ? -hi_q : hi_q;
                        end
                    end else begin
                        div_zero_d = 1'b0;
                        {dout_hi_d, dout_lo_d} = prod_fix;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            din1_q     <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dout_hi_q  <= '0;
            dout_lo_q  <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            dz_q       <= dz_d;
            din1_q     <= din1_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dout_hi_q  <= dout_hi_d;
            dout_lo_q  <= dout_lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign doutHi      = dout_hi_q;
    assign doutLo      = dout_lo_q;
    assign divZero     = div_zero_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_md_iter_unit.sv
// Testbench for md_iter_unit: directed cases plus random operations checked
// against an arithmetic reference model.

module tb_md_iter_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   mdOp;
    logic [W-1:0] din1;
    logic [W-1:0] din2;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] doutHi;
    logic [W-1:0] doutLo;
    logic         divZero;
    logic [1:0]   state_dbg;

    int n_cmp;
    int n_err;

    md_iter_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mdOp        (mdOp),
        .din1        (din1),
        .din2        (din2),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .doutHi      (doutHi),
        .doutLo      (doutLo),
        .divZero     (divZero),
        .state_dbg_o (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Returns {divZero, hi, lo} computed with plain 64-bit arithmetic.
    function automatic logic [2*W:0] ref_model(input logic [1:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint     sa, sb, p, q, r;
        logic [63:0] pu;
        logic [63:0] pv, qv, rv;
        if (op == 2'd0) begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
            pv = p;
            return {1'b0, pv};
        end
        if (op == 2'd1) begin
            pu = {32'b0, a} * {32'b0, b};
            return {1'b0, pu};
        end
        if (b == '0) begin
            return {1'b1, a, 32'hFFFF_FFFF};
        end
        if (op == 2'd2) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'b0, a};
            sb = {32'b0, b};
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {1'b0, rv[31:0], qv[31:0]};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        mdOp  = op;
        din1  = a;
        din2  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        // Operands are registered; scramble the inputs to prove it.
        din1  = $urandom;
        din2  = $urandom;
        mdOp  = 2'($urandom_range(0, 3));
        chk("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    // Waits for done (bounded) and checks latency, handshake and result.
    // Returns in the done cycle.
    task automatic wait_done(input string tag, input logic [2*W:0] exp);
        int lat;
        int idle_gaps;
        lat       = 0;
        idle_gaps = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
            if (!done && !busy) idle_gaps++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd33);
        chk({tag, "_busy_held"}, 32'(idle_gaps), 32'd0);
        chk({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
        chk({tag, "_hi"}, doutHi, exp[2*W-1:W]);
        chk({tag, "_lo"}, doutLo, exp[W-1:0]);
        chk({tag, "_divzero"}, {31'b0, divZero}, {31'b0, exp[2*W]});
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(op, a, b);
        wait_done(tag, ref_model(op, a, b));
        step();
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [2*W:0] exp_a;
        logic [2*W:0] exp_b;
        logic [W-1:0] ra, rb;
        logic [1:0]   rop;
        int           dones;

        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        mdOp  = 2'd0;
        din1  = '0;
        din2  = '0;

        // Reset state
        step();
        step();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", doutHi, 32'd0);
        chk("rst_lo", doutLo, 32'd0);
        chk("rst_divzero", {31'b0, divZero}, 32'd0);
        rst = 1'b1;
        step();

        // Directed cases with literal expectations
        start_op(2'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult_neg3x7", {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        step();
        chk("mult_neg3x7_done_pulse", {31'b0, done}, 32'd0);

        start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        step();

        start_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg7_2", {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        step();

        start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", {1'b0, 32'h0000_0000, 32'h8000_0000});
        step();

        start_op(2'd3, 32'd5, 32'd0);
        wait_done("divu_zero", {1'b1, 32'd5, 32'hFFFF_FFFF});
        step();

        // Remaining directed cases through the model
        run_op("multu_zero", 2'd1, 32'h0, 32'h1234_5678);
        run_op("divu_7_2", 2'd3, 32'd7, 32'd2);
        run_op("div_zero_signed", 2'd2, 32'hFFFF_FFF0, 32'd0);
        run_op("mult_2x3", 2'd0, 32'd2, 32'd3);

        // Flush mid-operation: prior result (2x3) must survive, no done.
        start_op(2'd3, 32'd100, 32'd7);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) dones++;
        end
        chk("flush_no_done", 32'(dones), 32'd0);
        chk("flush_hi_kept", doutHi, 32'd0);
        chk("flush_lo_kept", doutLo, 32'd6);
        chk("flush_dz_kept", {31'b0, divZero}, 32'd0);

        // start together with flush while idle is ignored
        mdOp  = 2'd1;
        din1  = 32'd9;
        din2  = 32'd9;
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        chk("idle_flush_start_busy", {31'b0, busy}, 32'd0);

        // Start while busy is ignored
        start_op(2'd1, 32'h0001_0003, 32'h0002_0005);
        repeat (4) step();
        mdOp  = 2'd3;
        din1  = 32'd77;
        din2  = 32'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        // five steps already elapsed since E0; wait_done counts from here
        begin
            int lat;
            lat = 5;
            while (!done && lat < 40) begin
                step();
                lat++;
            end
            chk("busy_start_latency", 32'(lat), 32'd33);
            exp_a = ref_model(2'd1, 32'h0001_0003, 32'h0002_0005);
            chk("busy_start_hi", doutHi, exp_a[2*W-1:W]);
            chk("busy_start_lo", doutLo, exp_a[W-1:0]);
        end
        step();
        chk("busy_start_no_second", {31'b0, busy}, 32'd0);

        // Back-to-back: second start presented in the done cycle
        exp_a = ref_model(2'd2, 32'hFFFF_FF38, 32'd13);
        exp_b = ref_model(2'd0, 32'h8000_0000, 32'h8000_0000);
        start_op(2'd2, 32'hFFFF_FF38, 32'd13);
        wait_done("b2b_first", exp_a);
        start_op(2'd0, 32'h8000_0000, 32'h8000_0000);
        chk("b2b_done_drop", {31'b0, done}, 32'd0);
        wait_done("b2b_second", exp_b);
        step();

        // Random operations
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick_operand();
            rb  = (rop[1] && $urandom_range(0, 5) == 0) ? 32'd0 : pick_operand();
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        // Reset mid-operation clears everything, no done afterwards
        start_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (19) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_hi", doutHi, 32'd0);
        chk("midrst_lo", doutLo, 32'd0);
        chk("midrst_dz", {31'b0, divZero}, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/md_iter_unit.md
Name: md_iter_unit

Overview:
Multi-cycle iterative multiply/divide engine for the EX stage. It computes MULT, MULTU, DIV and DIVU one bit per cycle. It drives the Hi/Lo write-back path (HiLo dinHi/dinLo) through a start/busy/done handshake. The hazard logic stalls IF/ID/EX while busy is high and any MFHI/MFLO or new mul/div instruction is pending.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clk      input   1      rising-edge clock
rst      input   1      synchronous reset, active-low
start    input   1      request a new operation; sampled only when idle
mdOp     input   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
din1     input   WIDTH  rs operand (multiplicand / dividend)
din2     input   WIDTH  rt operand (multiplier / divisor)
flush    input   1      abort the in-flight operation (exception/eret in pipeline)
busy     output  1      operation in progress
done     output  1      one-cycle pulse; doutHi/doutLo are valid
doutHi   output  WIDTH  MULT*: product[2W-1:W]; DIV*: remainder
doutLo   output  WIDTH  MULT*: product[W-1:0]; DIV*: quotient
divZero  output  1      sticky with the result: last division had din2 == 0

Behaviour:
- Reset: rst==0 at an edge sets state IDLE and busy, done, divZero, doutHi and doutLo to 0. Reset mid-operation discards all work; no done is produced.
- States:
  - IDLE: start==1 && flush==0 latches mdOp, din1 and din2; go to RUN; busy=1 from the next cycle.
  - RUN: iteration counter loads WIDTH and decrements each edge; one shift-add (multiply) or restoring shift-subtract (divide) step per edge; go to FIX when the counter reaches 1.
  - FIX: one edge for sign correction. Write doutHi, doutLo and divZero; done=1 and busy=0 for exactly the following cycle; return to IDLE.
- Latency: start sampled at edge E0; busy high E0..E33; results and done appear after edge E(WIDTH+1) (E33 when WIDTH=32). done lasts one cycle.
- Signed ops: operate on magnitudes, then correct sign in FIX.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Arithmetic is modulo 2^WIDTH per half.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0; no exception.
- Divide by zero (din2==0, DIV or DIVU): same latency; lo=all ones, hi=din1 as latched; divZero=1. MULT* always clears divZero.
- start while busy: ignored; the latched operands are unaffected. The upstream stall keeps the instruction held.
- flush: highest priority after reset.
  - In RUN or FIX: state goes to IDLE at the next edge, busy=0, no done; doutHi, doutLo and divZero keep their previous values.
  - In IDLE with start==1: start is ignored.
- start in the same cycle done is high: accepted, since the unit is IDLE.
- doutHi/doutLo hold the last result until the next FIX; HiLo writes only when done==1.
- Operands are registered at start; din1 and din2 may change freely afterwards.

Test Plan:
- MULT din1=0xFFFFFFFD (-3), din2=7 -> after 33 cycles: done=1 for 1 cycle, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy=0 on that cycle.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- MULTU 0x0 x 0x12345678 -> hi=0, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7/2 -> lo=3, hi=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, divZero=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, divZero=1.
- Following MULT 2x3 -> lo=6, hi=0, divZero=0.
- Start DIVU 100/7, then flush at cycle 10 -> busy=0 next cycle; no done; outputs keep their prior values.
- Start while busy (cycle 5) -> ignored; original result unchanged.
- rst=0 at cycle 20 -> all outputs 0.
- Back-to-back: start asserted in the done cycle -> second result after a further 33 cycles.
